// File: rtl/msb_pkg.sv
// Shared types, default sizing and parameter-legality helpers for the stream ring buffer.
package msb_pkg;

  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_NUM_STREAMS  = 4;
  localparam int DEF_STREAM_DEPTH = 64;
  localparam int DEF_SID_WIDTH    = $clog2(DEF_NUM_STREAMS);
  localparam int DEF_PTR_WIDTH    = $clog2(DEF_STREAM_DEPTH);

  typedef logic [DEF_SID_WIDTH-1:0] sid_t;
  typedef logic [DEF_PTR_WIDTH-1:0] ptr_t;
  typedef logic [DEF_PTR_WIDTH:0]   cnt_t;

  // Only a bare BRAM (1) or BRAM plus output register (2) is supported.
  function automatic bit read_latency_ok(input int rl);
    return (rl == 1) || (rl == 2);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/msb_out_fifo.sv
// Small register FIFO holding {sid, data} read results; valid/ready on the read side.
// Writes are never issued when full: the parent reserves a slot (credit) before each BRAM read.
module msb_out_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 66,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk2x,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_v,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_r,
  output logic [OCC_W-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             rd_fire;

  assign rd_fire   = rd_v & rd_r;
  assign rd_v      = (occ_reg != '0);
  assign rd_data   = mem[rd_ptr_reg];
  assign occupancy = occ_reg;

  // Storage is not reset; pointer reset alone discards stale entries.
  always_ff @(posedge clk2x) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (wr_en)   wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (rd_fire) rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      occ_reg <= occ_reg + OCC_W'(wr_en) - OCC_W'(rd_fire);
    end
  end

endmodule

// File: rtl/msb_stream_ring_buffer.sv
// NUM_STREAMS circular FIFOs sharing one simple-dual-port BRAM, region per stream = {sid, ptr}.
// Pops are credit-gated so every BRAM read already owns a slot in the output FIFO.
module msb_stream_ring_buffer
  import msb_pkg::*;
#(
  parameter  int DATA_WIDTH   = 64,
  parameter  int NUM_STREAMS  = 4,
  parameter  int STREAM_DEPTH = 64,
  parameter  int READ_LATENCY = 2,
  parameter  int OUT_DEPTH    = READ_LATENCY + 2,
  localparam int SID_WIDTH    = $clog2(NUM_STREAMS),
  localparam int PTR_WIDTH    = $clog2(STREAM_DEPTH),
  localparam int ADDR_WIDTH   = SID_WIDTH + PTR_WIDTH,
  localparam int CNT_WIDTH    = PTR_WIDTH + 1
) (
  input  logic                             clk2x,
  input  logic                             reset,
  input  logic                             i_push_v,
  input  logic [SID_WIDTH-1:0]             i_push_sid,
  input  logic [DATA_WIDTH-1:0]            i_push_data,
  output logic                             o_push_r,
  input  logic                             i_pop_v,
  input  logic [SID_WIDTH-1:0]             i_pop_sid,
  output logic                             o_pop_r,
  output logic                             o_rd_v,
  output logic [SID_WIDTH-1:0]             o_rd_sid,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  input  logic                             i_rd_r,
  output logic [NUM_STREAMS*CNT_WIDTH-1:0] o_count
);

  localparam int OCC_WIDTH = $clog2(OUT_DEPTH + 1);
  localparam int MEM_WORDS = NUM_STREAMS * STREAM_DEPTH;

  if (!read_latency_ok(READ_LATENCY) || !is_pow2(NUM_STREAMS) || !is_pow2(STREAM_DEPTH) ||
      (OUT_DEPTH < READ_LATENCY + 1)) begin : g_param_check
    $error("msb_stream_ring_buffer: illegal parameter combination");
  end

  logic [PTR_WIDTH-1:0]  head_reg  [NUM_STREAMS];
  logic [PTR_WIDTH-1:0]  tail_reg  [NUM_STREAMS];
  logic [CNT_WIDTH-1:0]  count_reg [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] push_hit;
  logic [NUM_STREAMS-1:0] pop_hit;
  logic                  push_fire;
  logic                  pop_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] bram_dout;

  logic [READ_LATENCY-1:0] tok_v;
  logic [SID_WIDTH-1:0]    tok_sid [READ_LATENCY];
  logic [OCC_WIDTH-1:0]    occupancy;
  logic [OCC_WIDTH-1:0]    in_flight;
  logic [OCC_WIDTH-1:0]    credits;

  // Ready terms use the pre-update count, so a same-cycle pop never frees a full stream
  // and a same-cycle push never feeds an empty one: read and write addresses cannot collide.
  assign o_push_r  = (count_reg[i_push_sid] != CNT_WIDTH'(STREAM_DEPTH));
  assign o_pop_r   = (count_reg[i_pop_sid] != '0) && (credits != '0);
  assign push_fire = i_push_v & o_push_r;
  assign pop_fire  = i_pop_v & o_pop_r;
  assign wr_addr   = {i_push_sid, head_reg[i_push_sid]};
  assign rd_addr   = {i_pop_sid, tail_reg[i_pop_sid]};

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
    assign push_hit[gi] = push_fire && (i_push_sid == SID_WIDTH'(gi));
    assign pop_hit[gi]  = pop_fire && (i_pop_sid == SID_WIDTH'(gi));
    assign o_count[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg[gi];
  end

  // Per-stream head/tail/count; pointers wrap naturally because STREAM_DEPTH is a power of 2.
  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        head_reg[s]  <= '0;
        tail_reg[s]  <= '0;
        count_reg[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (push_hit[s]) head_reg[s] <= head_reg[s] + PTR_WIDTH'(1);
        if (pop_hit[s])  tail_reg[s] <= tail_reg[s] + PTR_WIDTH'(1);
        count_reg[s] <= count_reg[s] + CNT_WIDTH'(push_hit[s]) - CNT_WIDTH'(pop_hit[s]);
      end
    end
  end

  // BRAM write port.
  always_ff @(posedge clk2x) begin
    if (push_fire) mem[wr_addr] <= i_push_data;
  end

  // BRAM read port, registered read.
  always_ff @(posedge clk2x) begin
    if (pop_fire) ram_q <= mem[rd_addr];
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic [DATA_WIDTH-1:0] ram_out;
    // BRAM output register, enabled by the stage-1 in-flight token.
    always_ff @(posedge clk2x or posedge reset) begin
      if (reset)         ram_out <= '0;
      else if (tok_v[0]) ram_out <= ram_q;
    end
    assign bram_dout = ram_out;
  end else begin : g_rl1
    assign bram_dout = ram_q;
  end

  // In-flight token pipe: one stage per cycle of BRAM read latency.
  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      tok_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tok_sid[i] <= '0;
    end else begin
      tok_v[0]   <= pop_fire;
      tok_sid[0] <= i_pop_sid;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tok_v[i]   <= tok_v[i-1];
        tok_sid[i] <= tok_sid[i-1];
      end
    end
  end

  // Credits ignore a same-cycle output pop: slightly conservative, never overflows.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + OCC_WIDTH'(tok_v[i]);
    credits = OCC_WIDTH'(OUT_DEPTH) - occupancy - in_flight;
  end

  msb_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (SID_WIDTH + DATA_WIDTH)
  ) u_out_fifo (
    .clk2x     (clk2x),
    .reset     (reset),
    .wr_en     (tok_v[READ_LATENCY-1]),
    .wr_data   ({tok_sid[READ_LATENCY-1], bram_dout}),
    .rd_v      (o_rd_v),
    .rd_data   ({o_rd_sid, o_rd_data}),
    .rd_r      (i_rd_r),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_msb_stream_ring_buffer.sv
// Directed + random bench for msb_stream_ring_buffer; scoreboard of per-stream models
// feeding an expected-output queue, compared whenever an element leaves the DUT.
module tb_msb_stream_ring_buffer;
  import msb_pkg::*;

  localparam int NS = DEF_NUM_STREAMS;
  localparam int SD = DEF_STREAM_DEPTH;
  localparam int CW = DEF_PTR_WIDTH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          push_v, push_r, pop_v, pop_r, rd_v, rd_r;
  sid_t          push_sid, pop_sid, rd_sid;
  logic [63:0]   push_data, rd_data;
  logic [NS*CW-1:0] count;

  logic          push1_v, push1_r, pop1_v, pop1_r, rd1_v, rd1_r;
  sid_t          push1_sid, pop1_sid, rd1_sid;
  logic [63:0]   push1_data, rd1_data;
  logic [NS*CW-1:0] count1;

  msb_stream_ring_buffer #(.READ_LATENCY(2)) u_dut (
    .clk2x(clk), .reset(reset),
    .i_push_v(push_v), .i_push_sid(push_sid), .i_push_data(push_data), .o_push_r(push_r),
    .i_pop_v(pop_v), .i_pop_sid(pop_sid), .o_pop_r(pop_r),
    .o_rd_v(rd_v), .o_rd_sid(rd_sid), .o_rd_data(rd_data), .i_rd_r(rd_r),
    .o_count(count)
  );

  msb_stream_ring_buffer #(.READ_LATENCY(1)) u_dut_rl1 (
    .clk2x(clk), .reset(reset),
    .i_push_v(push1_v), .i_push_sid(push1_sid), .i_push_data(push1_data), .o_push_r(push1_r),
    .i_pop_v(pop1_v), .i_pop_sid(pop1_sid), .o_pop_r(pop1_r),
    .o_rd_v(rd1_v), .o_rd_sid(rd1_sid), .o_rd_data(rd1_data), .i_rd_r(rd1_r),
    .o_count(count1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int s);
    return 64'(count[s*CW +: CW]);
  endfunction

  // Scoreboard: per-stream reference FIFOs and the expected output order.
  logic [63:0] mdl [NS][SD];
  int          mh [NS];
  int          mt [NS];
  int          mc [NS];
  logic [65:0] exp_q [$];
  logic [65:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      for (int s = 0; s < NS; s++) begin mh[s] = 0; mt[s] = 0; mc[s] = 0; end
    end else begin
      if (rd_v && rd_r) begin
        if (exp_q.size() == 0) check("out_unexpected", 64'(rd_v), 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("out_sid", 64'(rd_sid), 64'(mon_e[65:64]));
          check("out_data", rd_data, mon_e[63:0]);
        end
      end
      if (pop_v && pop_r) begin
        if (mc[pop_sid] == 0) check("pop_of_empty", 64'(pop_r), 64'd0);
        else begin
          exp_q.push_back({pop_sid, mdl[pop_sid][mh[pop_sid]]});
          mh[pop_sid] = (mh[pop_sid] + 1) % SD;
          mc[pop_sid]--;
        end
      end
      if (push_v && push_r) begin
        mdl[push_sid][mt[push_sid]] = push_data;
        mt[push_sid] = (mt[push_sid] + 1) % SD;
        mc[push_sid]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int s);
    int g;
    g = 0;
    rd_r = 1'b1; pop_sid = sid_t'(s); pop_v = 1'b1;
    while (cnt_of(s) != 64'd0 && g < 400) begin step(); g++; end
    pop_v = 1'b0;
    check($sformatf("drain%0d_count", s), cnt_of(s), 64'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((rd_v || exp_q.size() != 0) && g < 100) begin step(); g++; end
    check("idle_rd_v", 64'(rd_v), 64'd0);
    check("idle_exp_q", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push_one(input int s, input logic [63:0] d);
    push_v = 1'b1; push_sid = sid_t'(s); push_data = d;
    step();
    push_v = 1'b0;
  endtask

  int acc, g, lat0, lat1;

  initial begin
    reset = 1'b1;
    push_v = 0; push_sid = '0; push_data = '0; pop_v = 0; pop_sid = '0; rd_r = 1'b1;
    push1_v = 0; push1_sid = '0; push1_data = '0; pop1_v = 0; pop1_sid = '0; rd1_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pop_v = 1'b1;
    #1;
    check("rst_rd_v", 64'(rd_v), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_push_r", 64'(push_r), 64'd1);
    check("rst_pop_r", 64'(pop_r), 64'd0);
    pop_v = 1'b0;
    reset = 1'b0;
    step();

    // Fill sid2 with 0..63, then drain in order.
    for (int i = 0; i < SD; i++) begin
      push_v = 1'b1; push_sid = 2'd2; push_data = 64'(i);
      #1;
      check("t1_push_r", 64'(push_r), 64'd1);
      step();
    end
    push_v = 1'b0;
    #1;
    check("t1_push_r_full", 64'(push_r), 64'd0);
    check("t1_count_full", cnt_of(2), 64'd64);
    drain(2);
    wait_idle();

    // Pop latency for READ_LATENCY 2 and 1.
    push_v = 1'b1; push_sid = '0; push_data = 64'hA5;
    push1_v = 1'b1; push1_sid = '0; push1_data = 64'hA5;
    step();
    push_v = 1'b0; push1_v = 1'b0;
    pop_v = 1'b1; pop_sid = '0; pop1_v = 1'b1; pop1_sid = '0;
    #1;
    check("t2_pop_r", 64'(pop_r), 64'd1);
    check("t2_rl1_pop_r", 64'(pop1_r), 64'd1);
    check("t2_rl1_push_r", 64'(push1_r), 64'd1);
    step();
    pop_v = 1'b0; pop1_v = 1'b0;
    lat0 = 0; lat1 = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (rd_v && lat0 == 0) lat0 = k;
      if (rd1_v && lat1 == 0) begin
        lat1 = k;
        check("t2_rl1_data", rd1_data, 64'hA5);
        check("t2_rl1_sid", 64'(rd1_sid), 64'd0);
      end
    end
    check("t2_latency_rl2", 64'(lat0), 64'd2);
    check("t2_latency_rl1", 64'(lat1), 64'd1);
    check("t2_rl1_count", 64'(count1), 64'd0);
    wait_idle();

    // Full sid1 with push+pop held; empty sid3 with push+pop.
    for (int i = 0; i < SD; i++) push_one(1, 64'(100 + i));
    push_v = 1'b1; push_sid = 2'd1; push_data = 64'd200;
    pop_v = 1'b1; pop_sid = 2'd1;
    #1;
    check("t3_full_push_r", 64'(push_r), 64'd0);
    check("t3_full_pop_r", 64'(pop_r), 64'd1);
    step();
    check("t3_count_63", cnt_of(1), 64'd63);
    check("t3_push_r_after", 64'(push_r), 64'd1);
    step();
    check("t3_count_net", cnt_of(1), 64'd63);
    push_v = 1'b0; pop_v = 1'b0;
    push_v = 1'b1; push_sid = 2'd3; push_data = 64'd400;
    pop_v = 1'b1; pop_sid = 2'd3;
    #1;
    check("t3_empty_pop_r", 64'(pop_r), 64'd0);
    step();
    check("t3_count3", cnt_of(3), 64'd1);
    push_v = 1'b0; pop_v = 1'b0;
    drain(1);
    drain(3);
    wait_idle();

    // Backpressure: exactly OUT_DEPTH pops accepted while i_rd_r=0.
    for (int i = 0; i < 10; i++) push_one(0, 64'(300 + i));
    rd_r = 1'b0; pop_v = 1'b1; pop_sid = '0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pop_r) acc++;
      step();
    end
    check("t4_accepted", 64'(acc), 64'd4);
    check("t4_pop_r_blocked", 64'(pop_r), 64'd0);
    check("t4_count", cnt_of(0), 64'd6);
    check("t4_head_data", rd_data, 64'd300);
    rd_r = 1'b1;
    g = 0;
    while (acc < 10 && g < 100) begin
      @(negedge clk);
      if (pop_r) acc++;
      step();
      g++;
    end
    pop_v = 1'b0;
    check("t4_total", 64'(acc), 64'd10);
    wait_idle();

    // Random interleave across all streams with random backpressure.
    for (int k = 0; k < 500; k++) begin
      push_v = 1'($urandom_range(0, 1));
      push_sid = sid_t'($urandom_range(0, NS - 1));
      push_data = {$urandom, $urandom};
      pop_v = 1'($urandom_range(0, 1));
      pop_sid = sid_t'($urandom_range(0, NS - 1));
      rd_r = ($urandom_range(0, 3) != 0);
      step();
    end
    push_v = 1'b0; pop_v = 1'b0; rd_r = 1'b1;
    for (int s = 0; s < NS; s++) drain(s);
    wait_idle();

    // Reset with two reads in flight.
    for (int i = 0; i < 3; i++) push_one(0, 64'(500 + i));
    rd_r = 1'b0; pop_v = 1'b1; pop_sid = '0;
    step();
    step();
    pop_v = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_rd_v", 64'(rd_v), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_pop_r", 64'(pop_r), 64'd0);
    step();
    step();
    reset = 1'b0;
    pop_v = 1'b1; pop_sid = '0; rd_r = 1'b1;
    #1;
    check("t6_post_pop_r", 64'(pop_r), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_post_rd_v", 64'(rd_v), 64'd0);
    end
    pop_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
